// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encodings and constants for the serial sequence blocks
package seq_pkg;

  // Debug state codes, shared with the sequence-detector blocks' decoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd3
  } seq_state_e;

  // Reference pattern the detector blocks look for by default
  localparam logic [5:0] PAT_DEFAULT = 6'b101011;

endpackage

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - loadable MSB-first shift register with serial output
module seq_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_data;

  // Load takes priority over shift; zeros enter at the LSB end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

  assign o_sout = r_data[WIDTH-1];

endmodule

// File: rtl/seq_gen_tx.sv
// rtl/seq_gen_tx.sv - serial pattern transmitter, MSB first, with repeat count and gap
module seq_gen_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;

  // Request configuration captured at start; later input changes do not matter
  logic [WIDTH-1:0] r_pat_al;
  logic [LEN_W-1:0] r_len;
  logic [GAP_W-1:0] r_gap;

  // Down-counters: bits left in this pass (incl. current), passes left, gap cycles left
  logic [LEN_W-1:0] r_bit_cnt;
  logic [REP_W-1:0] r_pass_cnt;
  logic [GAP_W-1:0] r_gap_cnt;

  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_shamt;
  logic [REP_W-1:0] w_reps_eff;
  logic [WIDTH-1:0] w_pat_aligned;
  logic [WIDTH-1:0] w_sr_data;

  logic w_load_new;
  logic w_reload;
  logic w_shift;
  logic w_bit_dec;
  logic w_pass_dec;
  logic w_gap_load;
  logic w_gap_dec;
  logic w_sout;
  logic w_valid;

  // Over-long requests send the full register; zero passes means one pass
  assign w_len_eff  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  assign w_reps_eff = (reps == '0) ? REP_W'(1) : reps;

  // Left-align the pattern so bit len-1 sits at the shift register MSB
  assign w_shamt       = LEN_W'(WIDTH) - w_len_eff;
  assign w_pat_aligned = pat << w_shamt;

  // A fresh start loads from the inputs; later passes reload the latched copy
  assign w_sr_data = (r_state == IDLE) ? w_pat_aligned : r_pat_al;

  seq_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load_new | w_reload),
    .i_shift (w_shift),
    .i_data  (w_sr_data),
    .o_sout  (w_sout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and counter/shift control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load_new  = 1'b0;
    w_reload    = 1'b0;
    w_shift     = 1'b0;
    w_bit_dec   = 1'b0;
    w_pass_dec  = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (stop) begin
          w_state_nxt = DONE;
        end else if (start) begin
          if (len == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SHIFT;
            w_load_new  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (stop) begin
          w_state_nxt = DONE;
        end else if (r_bit_cnt > LEN_W'(1)) begin
          w_shift   = 1'b1;
          w_bit_dec = 1'b1;
        end else if (r_pass_cnt > REP_W'(1)) begin
          w_pass_dec = 1'b1;
          if (r_gap != '0) begin
            w_state_nxt = GAP;
            w_gap_load  = 1'b1;
          end else begin
            w_reload = 1'b1;
          end
        end else begin
          w_state_nxt = DONE;
        end
      end
      GAP: begin
        if (stop) begin
          w_state_nxt = DONE;
        end else if (r_gap_cnt > GAP_W'(1)) begin
          w_gap_dec = 1'b1;
        end else begin
          w_state_nxt = SHIFT;
          w_reload    = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request latch and down-counters; decrements saturate at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat_al   <= '0;
      r_len      <= '0;
      r_gap      <= '0;
      r_bit_cnt  <= '0;
      r_pass_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (w_load_new) begin
        r_pat_al   <= w_pat_aligned;
        r_len      <= w_len_eff;
        r_gap      <= gap;
        r_bit_cnt  <= w_len_eff;
        r_pass_cnt <= w_reps_eff;
      end else begin
        if (w_reload) begin
          r_bit_cnt <= r_len;
        end else if (w_bit_dec && (r_bit_cnt != '0)) begin
          r_bit_cnt <= r_bit_cnt - LEN_W'(1);
        end
        if (w_pass_dec && (r_pass_cnt != '0)) begin
          r_pass_cnt <= r_pass_cnt - REP_W'(1);
        end
      end
      if (w_gap_load) begin
        r_gap_cnt <= r_gap;
      end else if (w_gap_dec && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  // Outputs are decodes of registered state only; out is forced low off-pattern
  assign w_valid = (r_state == SHIFT);
  assign valid   = w_valid;
  assign out     = w_valid & w_sout;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign state   = r_state;

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb/tb_seq_gen_tx.sv - self-checking bench for seq_gen_tx
module tb_seq_gen_tx;
  import seq_pkg::*;

  typedef struct packed {
    logic       o;
    logic       v;
    logic       b;
    logic       d;
    logic [2:0] s;
  } exp_t;

  localparam int LOGN = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] pat;
  logic [3:0] len;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       dout;
  logic       valid;
  logic       busy;
  logic       done;
  logic [2:0] state;

  exp_t expq[$];
  exp_t act_log [LOGN];
  int   ncyc      = 0;
  bit   chk_en    = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   t0        = 0;
  int   model_len = 0;

  seq_gen_tx #(
    .WIDTH (8),
    .LEN_W (4),
    .REP_W (4),
    .GAP_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .pat   (pat),
    .len   (len),
    .reps  (reps),
    .gap   (gap),
    .out   (dout),
    .valid (valid),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic o, logic v, logic b, logic d, logic [2:0] s);
    exp_t e;
    e.o = o;
    e.v = v;
    e.b = b;
    e.d = d;
    e.s = s;
    return e;
  endfunction

  // Expected per-cycle stream of one request, built from the behavioural rules.
  // cut>0 truncates after that many cycles; cut_stop adds the DONE cycle, a reset cut does not.
  task automatic model_push(input logic [7:0] p, input int l, input int r, input int g,
                            input int cut, input bit cut_stop);
    exp_t q[$];
    int   le;
    int   re;
    le = (l > 8) ? 8 : l;
    re = (r == 0) ? 1 : r;
    if (le > 0) begin
      for (int k = 0; k < re; k++) begin
        for (int i = le - 1; i >= 0; i--) q.push_back(mk(p[i], 1'b1, 1'b1, 1'b0, 3'd1));
        if (k < re - 1) begin
          for (int j = 0; j < g; j++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd2));
        end
      end
    end
    if (cut > 0) begin
      while (q.size() > cut) void'(q.pop_back());
    end
    if (cut == 0 || cut_stop) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd3));
    foreach (q[i]) expq.push_back(q[i]);
    model_len = q.size();
    t0 = ncyc;
  endtask

  // Per-cycle comparison against the model; idle is expected when the model is empty
  task automatic monitor();
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ncyc++;
        a = {dout, valid, busy, done, state};
        if (expq.size() > 0) e = expq.pop_front();
        else e = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        act_log[ncyc % LOGN] = a;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_cmp t=%0d got o=%b v=%b b=%b d=%b s=%0d exp o=%b v=%b b=%b d=%b s=%0d",
                   ncyc, a.o, a.v, a.b, a.d, a.s, e.o, e.v, e.b, e.d, e.s);
        end
      end
    end
  endtask

  task automatic lit(input string name, input longint got, input longint exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  function automatic int vcount(int t, int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (act_log[(t + i) % LOGN].v) c++;
    return c;
  endfunction

  function automatic int done_at(int t, int n);
    for (int i = 1; i <= n; i++) if (act_log[(t + i) % LOGN].d) return i;
    return -1;
  endfunction

  function automatic logic [31:0] vbits(int t, int n);
    logic [31:0] b = '0;
    for (int i = 1; i <= n; i++) begin
      if (act_log[(t + i) % LOGN].v) b = {b[30:0], act_log[(t + i) % LOGN].o};
    end
    return b;
  endfunction

  // ev_kind: 0 none, 1 stop at ev_cyc, 2 reset at ev_cyc, 3 new start at ev_cyc, 4 start+stop together
  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] g, input int ev_kind, input int ev_cyc);
    @(posedge clk);
    #1;
    pat   = p;
    len   = l;
    reps  = r;
    gap   = g;
    start = 1'b1;
    if (ev_kind == 4) stop = 1'b1;
    @(posedge clk);
    if (ev_kind == 4)      model_push(p, 0, int'(r), int'(g), 0, 1'b0);
    else if (ev_kind == 1) model_push(p, int'(l), int'(r), int'(g), ev_cyc, 1'b1);
    else if (ev_kind == 2) model_push(p, int'(l), int'(r), int'(g), ev_cyc, 1'b0);
    else                   model_push(p, int'(l), int'(r), int'(g), 0, 1'b0);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (ev_kind >= 1 && ev_kind <= 3) begin
      repeat (ev_cyc - 1) @(posedge clk);
      #1;
      if (ev_kind == 1) stop = 1'b1;
      else if (ev_kind == 2) rst_n = 1'b0;
      else begin
        start = 1'b1;
        pat   = 8'hFF;
        len   = 4'd8;
        reps  = 4'd3;
        gap   = 4'd2;
      end
      @(posedge clk);
      #1;
      stop  = 1'b0;
      start = 1'b0;
      rst_n = 1'b1;
    end
    for (int i = 0; i < 300 && expq.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    pat   = '0;
    len   = '0;
    reps  = '0;
    gap   = '0;
    fork
      monitor();
    join_none
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // single pass
    send(8'b00101011, 4'd6, 4'd1, 4'd0, 0, 0);
    lit("model_len_single", model_len, 7);
    lit("single_bits", vbits(t0, 8), 32'(PAT_DEFAULT));
    lit("single_nvalid", vcount(t0, 8), 6);
    lit("single_done_cyc", done_at(t0, 8), 7);
    lit("single_busy_after", act_log[(t0 + 8) % LOGN].b, 0);

    // two passes with a three-cycle gap
    send(8'b00101011, 4'd6, 4'd2, 4'd3, 0, 0);
    lit("model_len_gap", model_len, 16);
    lit("gap_bits", vbits(t0, 17), 32'b101011101011);
    lit("gap_valid_7_9", vcount(t0 + 6, 3), 0);
    lit("gap_done_cyc", done_at(t0, 17), 16);

    // three passes back-to-back
    send(8'b00101011, 4'd6, 4'd3, 4'd0, 0, 0);
    lit("b2b_consecutive", vcount(t0, 18), 18);
    lit("b2b_bits", vbits(t0, 18), 32'b101011101011101011);
    lit("b2b_done_cyc", done_at(t0, 20), 19);

    // empty request
    send(8'b00101011, 4'd0, 4'd1, 4'd0, 0, 0);
    lit("empty_done_cyc", done_at(t0, 3), 1);
    lit("empty_nvalid", vcount(t0, 3), 0);

    // second start mid-pass is ignored
    send(8'b00101011, 4'd6, 4'd1, 4'd0, 3, 3);
    lit("ign_bits", vbits(t0, 9), 32'b101011);
    lit("ign_done_cyc", done_at(t0, 9), 7);

    // stop during shift
    send(8'b00101011, 4'd6, 4'd1, 4'd0, 1, 3);
    lit("stop_nvalid", vcount(t0, 6), 3);
    lit("stop_bits", vbits(t0, 6), 32'b101);
    lit("stop_done_cyc", done_at(t0, 6), 4);

    // reset mid-pass, then a fresh request
    send(8'b00101011, 4'd6, 4'd1, 4'd0, 2, 4);
    lit("rst_nvalid", vcount(t0, 6), 4);
    lit("rst_outputs_zero", act_log[(t0 + 5) % LOGN], 0);
    lit("rst_no_done", done_at(t0, 6), -1);
    send(8'b00101011, 4'd6, 4'd1, 4'd0, 0, 0);
    lit("fresh_bits", vbits(t0, 8), 32'b101011);
    lit("fresh_done_cyc", done_at(t0, 8), 7);

    // len above WIDTH clamps, reps=0 behaves as one pass
    send(8'b10110010, 4'd15, 4'd0, 4'd0, 0, 0);
    lit("clamp_bits", vbits(t0, 10), 32'hB2);
    lit("clamp_done_cyc", done_at(t0, 10), 9);

    // stop while in the gap
    send(8'b00101011, 4'd6, 4'd3, 4'd4, 1, 8);
    lit("stopgap_nvalid", vcount(t0, 10), 6);
    lit("stopgap_done_cyc", done_at(t0, 10), 9);

    // start and stop together in IDLE
    send(8'b00101011, 4'd6, 4'd1, 4'd0, 4, 0);
    lit("startstop_done_cyc", done_at(t0, 3), 1);
    lit("startstop_nvalid", vcount(t0, 3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen_tx.md
Name: seq_gen_tx

Overview:
Serial pattern transmitter: latches a parallel pattern word and shifts it out one bit per clock, MSB first.
- Supports programmable length, repeat count and inter-pass gap.
- Produces the bit streams consumed by the team's serial sequence-detector blocks; also usable as a stimulus source in loopback benches.
- Exposes its FSM state for debug, in the same way as the detector blocks.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of len input; must satisfy 2^LEN_W > WIDTH
REP_W, 4, width of reps input
GAP_W, 4, width of gap input

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request transmission; sampled only in IDLE
stop  input  1  abort current transmission
pat  input  WIDTH  pattern; bit len-1 is sent first, bit 0 last
len  input  LEN_W  bits per pass; 0 = empty request; values > WIDTH clamp to WIDTH
reps  input  REP_W  number of passes; 0 treated as 1
gap  input  GAP_W  idle cycles between passes; 0 = back-to-back
out  output  1  serial data bit
valid  output  1  out carries a pattern bit this cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of request
state  output  3  FSM state code: IDLE=0, SHIFT=1, GAP=2, DONE=3

Behaviour:
- Reset: when rst_n=0 at a rising edge, FSM goes to IDLE and out, valid, busy, done = 0, state = 0; all counters and the shift register clear. This applies in any state, including mid-pass.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.
- IDLE → SHIFT: start=1 at edge N with len≠0 latches pat, clamped len, effective reps and gap. From cycle N+1, out = pat[len-1] and valid=1.
- IDLE → DONE: start=1 with len=0 goes directly to DONE; no valid cycles.
- SHIFT: one bit per cycle, decrementing bit index; valid=1 throughout.
  - After bit 0 with passes remaining and gap≠0: go to GAP.
  - After bit 0 with passes remaining and gap=0: the next cycle carries pat[len-1] of the next pass, with no bubble.
  - After bit 0 of the final pass: go to DONE.
- GAP: exactly gap cycles with out=0, valid=0, busy=1; then SHIFT restarts from bit len-1.
- DONE: one cycle with done=1, busy=1, out=0, valid=0; then IDLE. A new start is accepted on the cycle after DONE.
- start outside IDLE: ignored; the latched pattern is unaffected by later changes to pat, len, reps or gap.
- stop: stop=1 in SHIFT or GAP means the next cycle is DONE; the bit on out in the stop cycle is the last one sent.
- Simultaneous start and stop in IDLE: stop wins, FSM goes to DONE, no bits are sent.
- out whenever valid=0: out=0.
- Counters: bit index LEN_W bits, pass counter REP_W bits, gap counter GAP_W bits; all count down and never wrap.

Decomposition:
- Shared package seq_pkg holds the state encodings (IDLE, SHIFT, GAP, DONE as 3-bit constants), so they are shared with the detector blocks' debug decoding. It also holds the default pattern constant PAT_DEFAULT = 6'b101011.
- One sub-module, seq_shift_reg: loadable MSB-first shift register with a load/shift enable and serial output.
- FSM and counters stay in the top module.

Test Plan:
- Single pass: pat=8'b00101011, len=6, reps=1, gap=0, start pulse at cycle 0.
  → out = 1,0,1,0,1,1 on cycles 1–6 with valid=1; done=1 on cycle 7; busy low from cycle 8.
- Repeat with gap: same pattern, reps=2, gap=3.
  → 101011 on cycles 1–6, valid=0 on cycles 7–9, 101011 on cycles 10–15, done on cycle 16.
- Back-to-back: reps=3, gap=0.
  → 18 consecutive valid bits (101011 ×3) with no bubble; done on cycle 19.
- Empty request: start with len=0.
  → done=1 on cycle 1; valid never asserts.
- Start ignored: start pulsed again at cycle 3 of a pass, with different pat.
  → original stream is unchanged.
- Abort and reset: stop at cycle 3, then a separate run with rst_n=0 at cycle 4.
  → stop run: 3 bits sent, done on cycle 4.
  → reset run: all outputs 0 and state=0 on the cycle after the reset edge; the next start behaves as a fresh request.
